// File: rtl/uart_wb_bridge_pkg.sv
// Shared types and byte constants for the UART-to-Wishbone debug bridge.
package uart_wb_bridge_pkg;

  // Bridge control states; command decode happens on the byte seen in IDLE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WB_REQ,
    S_RESP
  } state_e;

  // Command bytes (first byte of a frame).
  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;

  // Single-byte responses; read success returns the four data bytes instead.
  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_TMO    = 8'h45;
  localparam logic [7:0] RSP_BADCMD = 8'h3F;

endpackage

// File: rtl/uart_wb_bridge_if.sv
// Wishbone classic master/slave signal bundle used between the bridge and the SoC.
interface uart_wb_bridge_if;
  logic [31:0] wb_m2s_adr;
  logic [31:0] wb_m2s_dat;
  logic [3:0]  wb_m2s_sel;
  logic        wb_m2s_we;
  logic        wb_m2s_cyc;
  logic        wb_m2s_stb;
  logic [31:0] wb_s2m_dat;
  logic        wb_s2m_ack;

  modport master (
    output wb_m2s_adr, wb_m2s_dat, wb_m2s_sel, wb_m2s_we, wb_m2s_cyc, wb_m2s_stb,
    input  wb_s2m_dat, wb_s2m_ack
  );

  modport slave (
    input  wb_m2s_adr, wb_m2s_dat, wb_m2s_sel, wb_m2s_we, wb_m2s_cyc, wb_m2s_stb,
    output wb_s2m_dat, wb_s2m_ack
  );
endinterface

// File: rtl/uart_bridge_phy.sv
// 8N1 UART physical layer: synchronized RX deserializer and TX serializer.
// The TX ready flag also rises in the last cycle of a stop bit so a new byte
// offered then starts with no idle gap.
module uart_bridge_phy #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_start_i,
  output logic       tx_ready_o
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
  typedef enum logic       {T_IDLE, T_BUSY} tx_st_e;

  // ---------------- RX ----------------
  logic [2:0]    sync_q;
  rx_st_e        rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_s, rx_fall;

  assign rx_s    = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 3'b111;
    else         sync_q <= {sync_q[1:0], rx_i};
  end

  // RX state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // RX next state: mid-bit start check, 8 LSB-first data samples, stop check.
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_st_q)
      R_IDLE: if (rx_fall) begin
        rx_st_d  = R_START;
        rx_cnt_d = '0;
      end
      R_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s ? R_IDLE : R_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      R_STOP: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_st_d    = R_IDLE;
        rx_valid_d = rx_s;
        rx_ferr_d  = ~rx_s;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_st_d = R_IDLE;
    endcase
  end

  assign rx_byte_o  = rx_sh_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_ferr_o  = rx_ferr_q;

  // ---------------- TX ----------------
  tx_st_e        tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d;
  logic          tx_end;

  assign tx_end     = (tx_st_q == T_BUSY) && (tx_cnt_q == BIT_END) && (tx_bit_q == 4'd9);
  assign tx_ready_o = (tx_st_q == T_IDLE) || tx_end;

  // TX state register; line idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st_q  <= T_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
    end
  end

  // TX next state: bit index 0 is the start bit, 1..8 data, 9 stop.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    if (tx_start_i && tx_ready_o) begin
      tx_st_d  = T_BUSY;
      tx_cnt_d = '0;
      tx_bit_d = '0;
      tx_sh_d  = {1'b1, tx_byte_i};
      tx_d     = 1'b0;
    end else if (tx_st_q == T_BUSY) begin
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_st_d = T_IDLE;
          tx_d    = 1'b1;
        end else begin
          tx_d     = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end else tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone debug bridge: collects command frames from the PHY, runs one
// classic 32-bit Wishbone cycle, and streams the status/read data back out.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             i_uart_rx,
  output logic             o_uart_tx,
  output logic             o_busy,
  uart_wb_bridge_if.master wb
);

  localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;
  logic       tx_start, tx_ready;

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   resp_q, resp_d;
  logic [2:0]    resp_left_q, resp_left_d;

  uart_bridge_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk_i      (wb_clk),
    .rst_ni     (wb_rst_n),
    .rx_i       (i_uart_rx),
    .tx_o       (o_uart_tx),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr),
    .tx_byte_i  (resp_q[31:24]),
    .tx_start_i (tx_start),
    .tx_ready_o (tx_ready)
  );

  // Bridge state register; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      tmo_q       <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      tmo_q       <= tmo_d;
      resp_q      <= resp_d;
      resp_left_q <= resp_left_d;
    end
  end

  // Frame collection, bus cycle and response sequencing. Bytes and framing
  // errors arriving in WB_REQ/RESP fall through the case and are dropped.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    byte_cnt_d  = byte_cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    tmo_d       = tmo_q;
    resp_d      = resp_q;
    resp_left_d = resp_left_q;
    tx_start    = 1'b0;
    unique case (state_q)
      S_IDLE: if (rx_valid) begin
        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
          state_d    = S_ADDR;
          is_wr_d    = (rx_byte == CMD_WRITE);
          byte_cnt_d = '0;
        end else begin
          state_d     = S_RESP;
          resp_d      = {RSP_BADCMD, 24'h0};
          resp_left_d = 3'd1;
        end
      end
      S_ADDR: if (rx_ferr) begin
        state_d = S_IDLE;
      end else if (rx_valid) begin
        adr_d      = {adr_q[23:0], rx_byte};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          if (is_wr_q) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_WB_REQ;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            tmo_d   = '0;
          end
        end
      end
      S_WDATA: if (rx_ferr) begin
        state_d = S_IDLE;
      end else if (rx_valid) begin
        dat_d      = {dat_q[23:0], rx_byte};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          state_d = S_WB_REQ;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          tmo_d   = '0;
        end
      end
      S_WB_REQ: if (wb.wb_s2m_ack) begin
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        state_d = S_RESP;
        if (is_wr_q) begin
          resp_d      = {RSP_OK, 24'h0};
          resp_left_d = 3'd1;
        end else begin
          resp_d      = wb.wb_s2m_dat;
          resp_left_d = 3'd4;
        end
      end else if (tmo_q == TMO_LAST) begin
        cyc_d       = 1'b0;
        we_d        = 1'b0;
        state_d     = S_RESP;
        resp_d      = {RSP_TMO, 24'h0};
        resp_left_d = 3'd1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      S_RESP: if (tx_ready) begin
        if (resp_left_q != 3'd0) begin
          tx_start    = 1'b1;
          resp_d      = {resp_q[23:0], 8'h0};
          resp_left_d = resp_left_q - 3'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb.wb_m2s_adr = adr_q;
  assign wb.wb_m2s_dat = dat_q;
  assign wb.wb_m2s_sel = {4{cyc_q}};
  assign wb.wb_m2s_we  = we_q;
  assign wb.wb_m2s_cyc = cyc_q;
  assign wb.wb_m2s_stb = cyc_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: UART host driver, TX byte monitor and a
// configurable Wishbone slave, driven from a vector table plus corner sequences.
module tb_uart_wb_bridge;

  localparam int CPB  = 16;
  localparam int TMO  = 32;
  localparam int PER  = 10;
  localparam int BYTT = CPB * 10 * PER;   // one UART frame in time units

  logic wb_clk   = 1'b0;
  logic wb_rst_n = 1'b0;
  logic rx       = 1'b1;
  logic tx, busy;

  uart_wb_bridge_if wbi ();

  uart_wb_bridge #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TMO)) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .i_uart_rx (rx),
    .o_uart_tx (tx),
    .o_busy    (busy),
    .wb        (wbi)
  );

  always #(PER/2) wb_clk = ~wb_clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- Wishbone slave model ----------------
  int          slv_wait  = 0;
  bit          slv_never = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          wb_cnt = 0, stb_cnt = 0, last_len = 0, unstable_cnt = 0;
  logic [31:0] log_adr, log_dat;
  logic        log_we;
  logic [3:0]  log_sel;
  time         ack_t = 0;

  always @(negedge wb_clk) begin
    if (wbi.wb_m2s_cyc) begin
      if (stb_cnt == 0) begin
        log_adr = wbi.wb_m2s_adr;
        log_dat = wbi.wb_m2s_dat;
        log_we  = wbi.wb_m2s_we;
        log_sel = wbi.wb_m2s_sel;
        wb_cnt++;
      end else if (wbi.wb_m2s_adr !== log_adr || wbi.wb_m2s_dat !== log_dat ||
                   wbi.wb_m2s_we !== log_we || wbi.wb_m2s_sel !== log_sel)
        unstable_cnt++;
      if (wbi.wb_m2s_stb !== wbi.wb_m2s_cyc) unstable_cnt++;
      if (!slv_never && stb_cnt == slv_wait) begin
        wbi.wb_s2m_ack = 1'b1;
        wbi.wb_s2m_dat = slv_rdata;
        ack_t = $time;
      end else begin
        wbi.wb_s2m_ack = 1'b0;
      end
      stb_cnt++;
    end else begin
      wbi.wb_s2m_ack = 1'b0;
      wbi.wb_s2m_dat = 32'h0;
      if (stb_cnt != 0) last_len = stb_cnt;
      stb_cnt = 0;
    end
  end

  // ---------------- TX monitor ----------------
  logic [7:0] mon_b [$];
  time        mon_t [$];

  initial begin
    logic [7:0] b;
    time t0;
    wait (wb_rst_n);
    forever begin
      @(negedge tx iff wb_rst_n);
      t0 = $time;
      repeat (CPB/2) @(posedge wb_clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge wb_clk);
        b[i] = tx;
      end
      repeat (CPB) @(posedge wb_clk);
      mon_b.push_back(b);
      mon_t.push_back(t0);
    end
  end

  time busy_fall_t = 0;
  always @(negedge busy) busy_fall_t = $time;

  initial begin
    #(60000 * PER);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- host driver ----------------
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    logic [9:0] fr;
    fr = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      rx = fr[i];
      repeat (CPB-1) @(negedge wb_clk);
    end
    if (bad_stop) begin
      @(negedge wb_clk);
      rx = 1'b1;
      repeat (3*CPB) @(negedge wb_clk);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [8:0][7:0] frm;
    int              nfrm;
    int              wait_c;
    bit              never;
    logic [31:0]     rdata;
    int              exp_wb;
    logic [31:0]     exp_adr;
    logic [31:0]     exp_dat;
    logic            exp_we;
    int              exp_len;
    logic [3:0][7:0] rsp;
    int              nrsp;
  } vec_t;

  function automatic vec_t mk(input logic [8:0][7:0] f, input int n, input int w, input bit nv,
                              input logic [31:0] rd, input int ew, input logic [31:0] ea,
                              input logic [31:0] ed, input logic we, input int len,
                              input logic [3:0][7:0] r, input int nr);
    vec_t v;
    v.frm = f; v.nfrm = n; v.wait_c = w; v.never = nv; v.rdata = rd;
    v.exp_wb = ew; v.exp_adr = ea; v.exp_dat = ed; v.exp_we = we; v.exp_len = len;
    v.rsp = r; v.nrsp = nr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int wb0, uns0, rd0;
    wb0  = wb_cnt;
    uns0 = unstable_cnt;
    rd0  = mon_b.size();
    slv_wait  = v.wait_c;
    slv_never = v.never;
    slv_rdata = v.rdata;
    for (int i = 0; i < v.nfrm; i++) send_byte(v.frm[8-i], 1'b0);
    for (int c = 0; c < 6000 && mon_b.size() < rd0 + v.nrsp; c++) @(negedge wb_clk);
    chk({nm, "_resp_cnt"}, mon_b.size(), rd0 + v.nrsp);
    for (int c = 0; c < 2000 && busy; c++) @(negedge wb_clk);
    chk({nm, "_idle"}, busy, 1'b0);
    chk({nm, "_wb_cycles"}, wb_cnt - wb0, v.exp_wb);
    if (v.exp_wb != 0) begin
      chk({nm, "_adr"}, log_adr, v.exp_adr);
      chk({nm, "_we"}, log_we, v.exp_we);
      chk({nm, "_sel"}, log_sel, 4'hF);
      chk({nm, "_stb_len"}, last_len, v.exp_len);
      chk({nm, "_stable"}, unstable_cnt - uns0, 0);
      if (v.exp_we) chk({nm, "_dat"}, log_dat, v.exp_dat);
    end
    if (mon_b.size() >= rd0 + v.nrsp) begin
      for (int i = 0; i < v.nrsp; i++) begin
        chk($sformatf("%s_rsp%0d", nm, i), mon_b[rd0+i], v.rsp[3-i]);
        if (i > 0) chk($sformatf("%s_gap%0d", nm, i), 32'(mon_t[rd0+i] - mon_t[rd0+i-1]), BYTT);
      end
      chk({nm, "_busy_fall"}, 32'(busy_fall_t - mon_t[rd0+v.nrsp-1]), BYTT);
      if (v.exp_wb != 0 && !v.never)
        chk({nm, "_tx_latency"}, 32'(mon_t[rd0] - ack_t), 3*PER/2);
    end
  endtask

  vec_t vt [5];
  vec_t vrd, vwr;

  initial begin
    int wb0, rd0;
    vt[0] = mk({8'h57,8'h00,8'h00,8'h10,8'h00,8'hDE,8'hAD,8'hBE,8'hEF}, 9, 0, 0, 32'h0,
               1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1, {8'h4B,24'h0}, 1);
    vt[1] = mk({8'h52,8'h00,8'h00,8'h10,8'h00,32'h0}, 5, 3, 0, 32'hCAFE_F00D,
               1, 32'h0000_1000, 32'h0, 1'b0, 4, {8'hCA,8'hFE,8'hF0,8'h0D}, 4);
    vt[2] = mk({8'h52,8'h00,8'h00,8'h00,8'h40,32'h0}, 5, 0, 1, 32'h0,
               1, 32'h0000_0040, 32'h0, 1'b0, TMO, {8'h45,24'h0}, 1);
    vt[3] = mk({8'h11,64'h0}, 1, 0, 0, 32'h0,
               0, 32'h0, 32'h0, 1'b0, 0, {8'h3F,24'h0}, 1);
    vt[4] = mk({8'h57,8'h80,8'h00,8'h00,8'h04,8'h01,8'h02,8'h03,8'h04}, 9, 1, 0, 32'h0,
               1, 32'h8000_0004, 32'h0102_0304, 1'b1, 2, {8'h4B,24'h0}, 1);
    vrd   = mk({8'h52,8'h00,8'h00,8'h20,8'h04,32'h0}, 5, 0, 0, 32'h1234_5678,
               1, 32'h0000_2004, 32'h0, 1'b0, 1, {8'h12,8'h34,8'h56,8'h78}, 4);
    vwr   = vt[0];

    // Reset state
    repeat (3) @(negedge wb_clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_cyc", wbi.wb_m2s_cyc, 1'b0);
    chk("rst_stb", wbi.wb_m2s_stb, 1'b0);
    chk("rst_sel", wbi.wb_m2s_sel, 4'h0);
    chk("rst_we", wbi.wb_m2s_we, 1'b0);
    chk("rst_adr", wbi.wb_m2s_adr, 32'h0);
    chk("rst_busy", busy, 1'b0);
    wb_rst_n = 1'b1;
    repeat (5) @(negedge wb_clk);

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("v%0d", i));

    // Framing error on the third address byte discards the frame.
    wb0 = wb_cnt;
    rd0 = mon_b.size();
    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b1);
    chk("ferr_idle", busy, 1'b0);
    chk("ferr_no_wb", wb_cnt - wb0, 0);
    chk("ferr_no_resp", mon_b.size() - rd0, 0);
    run_vec(vrd, "ferr_read");

    // Reset in the middle of a bus cycle.
    slv_never = 1'b1;
    rd0 = mon_b.size();
    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h30, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int c = 0; c < 3000 && !wbi.wb_m2s_cyc; c++) @(negedge wb_clk);
    chk("mid_cyc_up", wbi.wb_m2s_cyc, 1'b1);
    repeat (5) @(negedge wb_clk);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", wbi.wb_m2s_cyc, 1'b0);
    chk("mid_rst_stb", wbi.wb_m2s_stb, 1'b0);
    chk("mid_rst_sel", wbi.wb_m2s_sel, 4'h0);
    chk("mid_rst_we", wbi.wb_m2s_we, 1'b0);
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (3*CPB*10) @(negedge wb_clk);
    chk("mid_rst_no_resp", mon_b.size() - rd0, 0);
    run_vec(vwr, "post_rst_wr");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
